// File: rtl/mem_block_mover_if.sv
// Bus bundle for mem_block_mover: the copy request/status handshake and the
// memory pins. The Fill/FillValue pins exist only when MEM_MOVER_FILL_EN is defined.
interface mem_block_mover_if #(
    parameter int W = 8,
    parameter int A = 8
);
    logic         Start;
    logic [A-1:0] SrcAddr;
    logic [A-1:0] DstAddr;
    logic [A-1:0] Length;
    logic         Busy;
    logic         Done;
    logic [A-1:0] MemAddress;
    logic         MemWriteEn;
    logic [W-1:0] MemWrData;
    logic [W-1:0] MemRdData;
`ifdef MEM_MOVER_FILL_EN
    logic         Fill;
    logic [W-1:0] FillValue;
`endif

    modport master (
`ifdef MEM_MOVER_FILL_EN
        input  Fill, FillValue,
`endif
        input  Start, SrcAddr, DstAddr, Length, MemRdData,
        output Busy, Done, MemAddress, MemWriteEn, MemWrData
    );

    modport slave (
`ifdef MEM_MOVER_FILL_EN
        output Fill, FillValue,
`endif
        output Start, SrcAddr, DstAddr, Length, MemRdData,
        input  Busy, Done, MemAddress, MemWriteEn, MemWrData
    );
endinterface

// File: rtl/mem_block_mover.sv
// Memory-to-memory block copier with memmove semantics (read/write ping-pong).
// Optional constant-fill mode is compiled in with MEM_MOVER_FILL_EN.
module mem_block_mover #(
    parameter int W = 8,
    parameter int A = 8
) (
    input  logic              Clk,
    input  logic              Reset_n,
    mem_block_mover_if.master bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t       state_q, state_d;
    logic [A-1:0] src_q, src_d;
    logic [A-1:0] dst_q, dst_d;
    logic [A-1:0] rem_q, rem_d;
    logic         bwd_q, bwd_d;
    logic         fill_q, fill_d;
    logic [W-1:0] hold_q, hold_d;
    logic [A-1:0] addr_q, addr_d;
    logic         we_q, we_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic         fill_in;
    logic [W-1:0] fill_val;
    logic [A-1:0] diff;
    logic         bwd_start;
    logic [A-1:0] src_start, dst_start;
    logic [A-1:0] src_step, dst_step;

`ifdef MEM_MOVER_FILL_EN
    assign fill_in  = bus.Fill;
    assign fill_val = bus.FillValue;
`else
    assign fill_in  = 1'b0;
    assign fill_val = '0;
`endif

    // Copy backwards only when the destination starts inside the source window,
    // otherwise a forward copy would overwrite bytes not yet read.
    assign diff      = bus.DstAddr - bus.SrcAddr;
    assign bwd_start = !fill_in && (diff != '0) && (diff < bus.Length);
    assign src_start = bwd_start ? (bus.SrcAddr + bus.Length - A'(1)) : bus.SrcAddr;
    assign dst_start = bwd_start ? (bus.DstAddr + bus.Length - A'(1)) : bus.DstAddr;
    assign src_step  = bwd_q ? (src_q - A'(1)) : (src_q + A'(1));
    assign dst_step  = bwd_q ? (dst_q - A'(1)) : (dst_q + A'(1));

    // Outputs are computed for the state being entered so they appear registered.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        bwd_d   = bwd_q;
        fill_d  = fill_q;
        hold_d  = hold_q;
        addr_d  = '0;
        we_d    = 1'b0;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.Start) begin
                    busy_d = 1'b1;
                    fill_d = fill_in;
                    bwd_d  = bwd_start;
                    src_d  = src_start;
                    dst_d  = dst_start;
                    rem_d  = bus.Length;
                    if (bus.Length == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (fill_in) begin
                        state_d = WRITE;
                        addr_d  = dst_start;
                        we_d    = 1'b1;
                        hold_d  = fill_val;
                    end else begin
                        state_d = READ;
                        addr_d  = src_start;
                    end
                end
            end
            READ: begin
                hold_d  = bus.MemRdData;
                state_d = WRITE;
                addr_d  = dst_q;
                we_d    = 1'b1;
            end
            WRITE: begin
                src_d = src_step;
                dst_d = dst_step;
                rem_d = rem_q - A'(1);
                if (rem_q == A'(1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (fill_q) begin
                    state_d = WRITE;
                    addr_d  = dst_step;
                    we_d    = 1'b1;
                end else begin
                    state_d = READ;
                    addr_d  = src_step;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            bwd_q   <= 1'b0;
            fill_q  <= 1'b0;
            hold_q  <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            bwd_q   <= bwd_d;
            fill_q  <= fill_d;
            hold_q  <= hold_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.Busy       = busy_q;
    assign bus.Done       = done_q;
    assign bus.MemAddress = addr_q;
    assign bus.MemWriteEn = we_q;
    assign bus.MemWrData  = hold_q;
endmodule
